// File: rtl/debug_ocimem_ctrl.sv
// debug_ocimem_ctrl: debug on-chip memory controller.
//   The JTAG side takes strobes from the debug wrapper's sysclk stage and reads
//   or writes one word of a small debug RAM. The result goes back through
//   MonDReg, monitor_ready and monitor_error. A CPU slave port shares the same
//   RAM, and a JTAG access always stalls the CPU.
// Ports:
//   clk, reset                  system clock, async active-high reset
//   jdo[37:0]                   JTAG data: [ADDR_W+1:2] addr, [34] read,
//                               [35] clear error, [36] autoinc, [31:0] wdata
//   take_action_ocimem_a/b      load-address(/read) strobe, write-data strobe
//   take_no_action_ocimem_a     read-next strobe
//   MonDReg, monitor_ready,     registered results to the wrapper
//   monitor_error
//   cpu_*                       single-cycle slave port, read data 1 cycle later
module debug_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic              cpu_waitrequest
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DATA, WR} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   mona_q;
  logic                autoinc_q;
  logic                rd_oor_q;
  logic [DATA_W-1:0]   ram_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic sa, sb, sn;
  assign sa = take_action_ocimem_a;
  assign sb = take_action_ocimem_b;
  assign sn = take_no_action_ocimem_a;

  logic any_strobe, multi_strobe;
  assign any_strobe   = sa | sb | sn;
  assign multi_strobe = (sa & sb) | (sa & sn) | (sb & sn);

  logic jtag_inr, cpu_inr;
  assign jtag_inr = {1'b0, mona_q} < DEPTH_L;
  assign cpu_inr  = {1'b0, cpu_address} < DEPTH_L;

  // The CPU is stalled while JTAG owns the RAM port, and also in the IDLE cycle
  // where a strobe arrives. That way a CPU access never races the JTAG access
  // being launched.
  assign cpu_waitrequest = (state_q == RD_ISSUE) || (state_q == WR) ||
                           ((state_q == IDLE) && any_strobe);

  logic cpu_wr_go, cpu_rd_go, jtag_wr_go;
  assign cpu_wr_go  = cpu_write & ~cpu_waitrequest & cpu_inr;
  assign cpu_rd_go  = cpu_read & ~cpu_write & ~cpu_waitrequest;
  assign jtag_wr_go = (state_q == WR) & jtag_inr;

  logic [ADDR_W-1:0] mona_inc;
  assign mona_inc = mona_q + ADDR_W'(autoinc_q);  // wraps modulo 2**ADDR_W

  // RAM is not reset. JTAG and CPU writes can never land in the same cycle,
  // because the CPU is stalled in WR.
  always_ff @(posedge clk) begin
    if (jtag_wr_go)
      mem[mona_q[IDX_W-1:0]] <= MonDReg;
    else if (cpu_wr_go)
      mem[cpu_address[IDX_W-1:0]] <= cpu_writedata;
    if (state_q == RD_ISSUE)
      ram_q <= mem[mona_q[IDX_W-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_readdata      <= '0;
      cpu_readdatavalid <= 1'b0;
    end else begin
      cpu_readdatavalid <= cpu_rd_go;
      if (cpu_rd_go)
        cpu_readdata <= cpu_inr ? mem[cpu_address[IDX_W-1:0]] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mona_q        <= '0;
      autoinc_q     <= 1'b0;
      rd_oor_q      <= 1'b0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sa) begin
            mona_q    <= jdo[ADDR_W+1:2];
            autoinc_q <= jdo[36];
            if (jdo[35]) monitor_error <= 1'b0;
            if (jdo[34]) begin
              monitor_ready <= 1'b0;
              state_q       <= RD_ISSUE;
            end else begin
              monitor_ready <= 1'b1;
            end
          end else if (sb) begin
            MonDReg       <= jdo[DATA_W-1:0];
            monitor_ready <= 1'b0;
            state_q       <= WR;
          end else if (sn) begin
            monitor_ready <= 1'b0;
            state_q       <= RD_ISSUE;
          end
          // Placed after the clear, so an error raised in the same cycle wins.
          if (multi_strobe) monitor_error <= 1'b1;
        end
        RD_ISSUE: begin
          rd_oor_q <= ~jtag_inr;
          if (!jtag_inr) monitor_error <= 1'b1;
          state_q <= RD_DATA;
        end
        RD_DATA: begin
          MonDReg       <= rd_oor_q ? DATA_W'(32'hDEADBEEF) : ram_q;
          mona_q        <= mona_inc;
          monitor_ready <= 1'b1;
          state_q       <= IDLE;
        end
        WR: begin
          if (!jtag_inr) monitor_error <= 1'b1;
          mona_q        <= mona_inc;
          monitor_ready <= 1'b1;
          state_q       <= IDLE;
        end
      endcase
      if ((state_q != IDLE) && any_strobe) monitor_error <= 1'b1;
    end
  end

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37], jdo[33:32]};

endmodule

// File: doc/debug_ocimem_ctrl.md
Name: debug_ocimem_ctrl

Overview:
Debug on-chip memory controller, directly downstream of the JTAG debug-module wrapper's system-clock stage. It consumes jdo and the ocimem take-action strobes and performs debugger reads and writes into a small dual-access debug RAM. It returns MonDReg, monitor_ready and monitor_error to the wrapper. A CPU-side slave port shares the same RAM; JTAG accesses take priority over it.

Parameters:
ADDR_W, 8, word-address width of debug RAM
DEPTH, 256, implemented words (DEPTH <= 2**ADDR_W); addresses >= DEPTH are out of range
DATA_W, 32, data width (fixed 32; MonDReg width)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
jdo  in  38  JTAG data from the sysclk stage
take_action_ocimem_a  in  1  command strobe: load address / start read
take_action_ocimem_b  in  1  data strobe: write jdo[31:0] to RAM
take_no_action_ocimem_a  in  1  read-next strobe
MonDReg  out  32  monitor data register to the wrapper
monitor_ready  out  1  last JTAG access complete
monitor_error  out  1  sticky error flag
cpu_address  in  ADDR_W  CPU word address
cpu_read  in  1  CPU read request
cpu_write  in  1  CPU write request
cpu_writedata  in  32  CPU write data
cpu_readdata  out  32  CPU read data
cpu_readdatavalid  out  1  one-cycle pulse with cpu_readdata
cpu_waitrequest  out  1  CPU request not accepted this cycle

Behaviour:
- Reset (async, active-high): MonDReg=0, MonAReg=0, autoinc=0, monitor_ready=0, monitor_error=0, cpu_readdata=0, cpu_readdatavalid=0, FSM=IDLE. RAM contents are not reset.
- jdo fields on take_action_ocimem_a: jdo[ADDR_W+1:2]=word address; jdo[34]=read request; jdo[35]=clear monitor_error; jdo[36]=auto-increment enable.
- FSM states: IDLE, RD_ISSUE, RD_DATA, WR.
- IDLE + take_action_ocimem_a: MonAReg<=addr, autoinc<=jdo[36], monitor_ready<=0. If jdo[35], clear monitor_error (a new error in the same cycle wins). If jdo[34], go to RD_ISSUE; else monitor_ready<=1 next cycle and stay IDLE.
- IDLE + take_action_ocimem_b: MonDReg<=jdo[31:0], monitor_ready<=0, go to WR.
- IDLE + take_no_action_ocimem_a: go to RD_ISSUE using the current MonAReg, monitor_ready<=0.
- RD_ISSUE: RAM read issued at MonAReg -> RD_DATA.
- RD_DATA: MonDReg<=RAM data; MonAReg+=autoinc; monitor_ready<=1 -> IDLE. Latency from strobe to monitor_ready=1 is 3 cycles.
- WR: RAM write MonDReg at MonAReg; MonAReg+=autoinc; monitor_ready<=1 -> IDLE. Latency 2 cycles.
- Out-of-range (MonAReg >= DEPTH) in RD_ISSUE or WR:
  - no RAM access;
  - monitor_error<=1 (sticky);
  - a read returns MonDReg=32'hDEADBEEF;
  - monitor_ready still asserts on schedule.
- MonAReg increment wraps modulo 2**ADDR_W.
- Strobe priority when simultaneous: take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a. Lower-priority strobes in that cycle are dropped and monitor_error<=1.
- Any strobe while FSM != IDLE is ignored and sets monitor_error=1; the in-flight access completes normally.
- CPU port:
  - cpu_waitrequest=1 combinationally while the FSM is in RD_ISSUE or WR, or in the IDLE cycle where any JTAG strobe is present; otherwise 0.
  - Accepted CPU read: cpu_readdata valid with a cpu_readdatavalid pulse exactly 1 cycle later.
  - Accepted CPU write: commits that cycle.
  - cpu_read and cpu_write both high: write performed, no read response.
  - CPU out-of-range read returns 0; out-of-range write is dropped. CPU accesses never affect monitor_error.
- Reset mid-operation aborts the access. A write in WR during reset is not guaranteed to commit.

Test Plan:
- Reset then idle -> MonDReg=0, monitor_ready=0, monitor_error=0, cpu_waitrequest=0.
- ocimem_a with addr=0x10, jdo[36]=1, read=0; then ocimem_b with 0x12345678, then ocimem_b with 0xCAFEF00D -> RAM[0x10]=0x12345678, RAM[0x11]=0xCAFEF00D, MonAReg=0x12; monitor_ready=1 two cycles after each b strobe.
- ocimem_a with addr=0x10, read=1, autoinc=1; then take_no_action_ocimem_a -> MonDReg=0x12345678 three cycles after the a strobe with monitor_ready=1; after the no-action strobe, MonDReg=0xCAFEF00D.
- DEPTH=256, ADDR_W=9, read at addr 0x100 -> MonDReg=0xDEADBEEF, monitor_error=1. Later ocimem_a with jdo[35]=1 -> monitor_error=0.
- CPU read of 0x11 issued in the same cycle as an ocimem_b strobe -> cpu_waitrequest=1 until WR completes. The CPU then reads 0x11 (new data if the address matched) with cpu_readdatavalid exactly 1 cycle after acceptance.
- Assert reset while in RD_ISSUE -> next cycle FSM=IDLE, monitor_ready=0, MonDReg=0. A following strobe is accepted normally with no error.
